// File: rtl/samp_gen_mc.sv
// Multi-channel sample generator: steps a shared index every `speed` ticks and reads one
// phase-offset sample per channel from a single-port RAM. Bounce mode needs SAMP_GEN_MC_BOUNCE_EN.
module samp_gen_mc #(
   parameter int unsigned NSAMP_WID = 10,
   parameter int unsigned NCHAN     = 4,
   parameter int unsigned DATA_WID  = 16
) (
   input  logic                       clk_tx,
   input  logic                       rst_clk_tx,
   input  logic                       en_clk_samp,
   input  logic                       go_clk_tx,
   input  logic                       stop_clk_tx,
   input  logic [1:0]                 mode_clk_tx,
   input  logic [NSAMP_WID:0]         nsamp_clk_tx,
   input  logic [15:0]                spd_clk_tx,
   input  logic [NCHAN*NSAMP_WID-1:0] phase_clk_tx,
   output logic [NSAMP_WID-1:0]       ram_addr,
   output logic                       ram_rd_en,
   input  logic [DATA_WID-1:0]        ram_dout,
   output logic [NCHAN*DATA_WID-1:0]  samp,
   output logic                       samp_val,
   output logic                       busy,
   output logic [7:0]                 led_o
);

   localparam int unsigned NW      = NSAMP_WID + 1;
   localparam int unsigned SEQ_WID = $clog2(NCHAN + 1);

   localparam logic [SEQ_WID-1:0] SEQ_LAST = SEQ_WID'(NCHAN);
   localparam logic [0:0]         StIdle   = 1'b0;
   localparam logic [0:0]         StRun    = 1'b1;

   logic [0:0]                state_q, state_d;
   logic                      go_pend_q, go_pend_d;
   logic                      stop_pend_q, stop_pend_d;
   logic [1:0]                mode_q, mode_d;
   logic [NW-1:0]             nsamp_q, nsamp_d;
   logic [NW-1:0]             cnt_q, cnt_d;
   logic [15:0]               spd_cnt_q, spd_cnt_d;
   logic [SEQ_WID-1:0]        seq_q, seq_d;
   logic [NSAMP_WID-1:0]      addr_q, addr_d;
   logic [NCHAN*DATA_WID-1:0] stg_q, stg_d;
   logic [NCHAN*DATA_WID-1:0] samp_q, samp_d;
   logic                      samp_val_q, samp_val_d;
   logic [7:0]                led_q, led_d;
`ifdef SAMP_GEN_MC_BOUNCE_EN
   logic                      dir_q, dir_d;  // 1: counting down
`endif

   logic        go_eff, stop_eff;
   logic        step, step_now, relatch, is_oneshot;
   logic [15:0] spd_m1;

   // (cnt + phase) mod n with out-of-range phases folded to 0; cnt < n so one subtract suffices.
   function automatic logic [NSAMP_WID-1:0] chan_addr(input logic [NW-1:0]        cnt,
                                                      input logic [NSAMP_WID-1:0] ph,
                                                      input logic [NW-1:0]        n);
      logic [NW-1:0] ph_e;
      logic [NW-1:0] sum;
      ph_e = ({1'b0, ph} >= n) ? '0 : {1'b0, ph};
      sum  = cnt + ph_e;
      if (sum >= n) begin
         sum = sum - n;
      end
      return sum[NSAMP_WID-1:0];
   endfunction

   assign go_eff     = go_pend_q | go_clk_tx;
   assign stop_eff   = stop_pend_q | stop_clk_tx;
   assign is_oneshot = (mode_q == 2'b00) || (mode_q == 2'b11);
   assign spd_m1     = (spd_clk_tx == 16'd0) ? 16'd0 : spd_clk_tx - 16'd1;
   assign step_now   = step & ~rst_clk_tx;

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      nsamp_d     = nsamp_q;
      cnt_d       = cnt_q;
      spd_cnt_d   = spd_cnt_q;
      step        = 1'b0;
      relatch     = 1'b0;
      go_pend_d   = en_clk_samp ? 1'b0 : go_eff;
      stop_pend_d = en_clk_samp ? 1'b0 : stop_eff;
`ifdef SAMP_GEN_MC_BOUNCE_EN
      dir_d       = dir_q;
`endif
      if (en_clk_samp) begin
         case (state_q)
            StIdle: begin
               if (!stop_eff && go_eff && (nsamp_clk_tx != '0)) begin
                  state_d = StRun;
                  mode_d  = mode_clk_tx;
                  nsamp_d = nsamp_clk_tx;
                  cnt_d   = '0;
                  step    = 1'b1;
`ifdef SAMP_GEN_MC_BOUNCE_EN
                  dir_d   = 1'b0;
`endif
               end
            end
            StRun: begin
               if (stop_eff) begin
                  state_d = StIdle;
               end else if (spd_cnt_q != 16'd0) begin
                  spd_cnt_d = spd_cnt_q - 16'd1;
               end else begin
                  step = 1'b1;
`ifdef SAMP_GEN_MC_BOUNCE_EN
                  if (mode_q == 2'b10) begin
                     if (dir_q) begin
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == NW'(1)) begin
                           dir_d   = 1'b0;
                           relatch = 1'b1;
                        end
                     end else if (cnt_q == nsamp_q - 1'b1) begin
                        if (nsamp_q == NW'(1)) begin
                           cnt_d   = '0;
                           relatch = 1'b1;
                        end else begin
                           // Turn around; with n=2 this lands straight back on 0.
                           cnt_d = cnt_q - 1'b1;
                           if (cnt_q == NW'(1)) begin
                              relatch = 1'b1;
                           end else begin
                              dir_d = 1'b1;
                           end
                        end
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end else
`endif
                  if (cnt_q == nsamp_q - 1'b1) begin
                     if (is_oneshot && !go_eff) begin
                        state_d = StIdle;
                        step    = 1'b0;
                     end else begin
                        cnt_d   = '0;
                        relatch = 1'b1;
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
                  if (relatch) begin
                     if (nsamp_clk_tx == '0) begin
                        state_d = StIdle;
                        step    = 1'b0;
                     end else begin
                        mode_d  = mode_clk_tx;
                        nsamp_d = nsamp_clk_tx;
                     end
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
      if (step) begin
         spd_cnt_d = spd_m1;
      end
   end

   // Channel 0 is read in the step-tick cycle itself so the publish lands NCHAN+1 cycles later.
   always_comb begin
      ram_rd_en = 1'b0;
      ram_addr  = addr_q;
      if (step_now) begin
         ram_rd_en = 1'b1;
         ram_addr  = chan_addr(cnt_d, phase_clk_tx[NSAMP_WID-1:0], nsamp_d);
      end else if ((seq_q != '0) && (seq_q < SEQ_LAST)) begin
         ram_rd_en = 1'b1;
         ram_addr  = chan_addr(cnt_q, phase_clk_tx[int'(seq_q)*NSAMP_WID +: NSAMP_WID], nsamp_q);
      end
   end

   always_comb begin
      addr_d     = ram_addr;
      stg_d      = stg_q;
      samp_d     = samp_q;
      samp_val_d = 1'b0;
      led_d      = samp_q[DATA_WID-1 -: 8];
      if (step_now) begin
         seq_d = SEQ_WID'(1);
      end else if ((seq_q == '0) || (seq_q == SEQ_LAST)) begin
         seq_d = '0;
      end else begin
         seq_d = seq_q + 1'b1;
      end
      if (seq_q != '0) begin
         stg_d[(int'(seq_q) - 1)*DATA_WID +: DATA_WID] = ram_dout;
      end
      if (seq_q == SEQ_LAST) begin
         samp_d     = stg_d;
         samp_val_d = 1'b1;
      end
   end

   always_ff @(posedge clk_tx) begin
      if (rst_clk_tx) begin
         state_q     <= StIdle;
         go_pend_q   <= 1'b0;
         stop_pend_q <= 1'b0;
         mode_q      <= 2'b00;
         nsamp_q     <= '0;
         cnt_q       <= '0;
         spd_cnt_q   <= 16'd0;
         seq_q       <= '0;
         addr_q      <= '0;
         stg_q       <= '0;
         samp_q      <= '0;
         samp_val_q  <= 1'b0;
         led_q       <= 8'd0;
`ifdef SAMP_GEN_MC_BOUNCE_EN
         dir_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         go_pend_q   <= go_pend_d;
         stop_pend_q <= stop_pend_d;
         mode_q      <= mode_d;
         nsamp_q     <= nsamp_d;
         cnt_q       <= cnt_d;
         spd_cnt_q   <= spd_cnt_d;
         seq_q       <= seq_d;
         addr_q      <= addr_d;
         stg_q       <= stg_d;
         samp_q      <= samp_d;
         samp_val_q  <= samp_val_d;
         led_q       <= led_d;
`ifdef SAMP_GEN_MC_BOUNCE_EN
         dir_q       <= dir_d;
`endif
      end
   end

   assign samp     = samp_q;
   assign samp_val = samp_val_q;
   assign busy     = (state_q == StRun);
   assign led_o    = led_q;

endmodule

// File: tb/tb_samp_gen_mc.sv
// Directed bench for samp_gen_mc (NCHAN=4, DATA_WID=16); RAM holds RAM[i] = i*257.
module tb_samp_gen_mc;

   localparam int TP = 8;  // tick period in clk_tx cycles

   logic        clk = 1'b0;
   logic        rst, en, go, stop;
   logic [1:0]  mode;
   logic [10:0] nsamp;
   logic [15:0] spd;
   logic [39:0] phase;
   logic [9:0]  ram_addr;
   logic        ram_rd_en;
   logic [15:0] ram_dout;
   logic [63:0] samp;
   logic        samp_val, busy;
   logic [7:0]  led;
   logic        tick_on;

   logic [15:0] mem [0:1023];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0, last_tick = 0, run = 0;
   logic [63:0] samp_q[$];
   int          lat_q[$], scyc_q[$], start_q[$], len_q[$];
   int          bexp[8];

   samp_gen_mc dut (
      .clk_tx       (clk),
      .rst_clk_tx   (rst),
      .en_clk_samp  (en),
      .go_clk_tx    (go),
      .stop_clk_tx  (stop),
      .mode_clk_tx  (mode),
      .nsamp_clk_tx (nsamp),
      .spd_clk_tx   (spd),
      .phase_clk_tx (phase),
      .ram_addr     (ram_addr),
      .ram_rd_en    (ram_rd_en),
      .ram_dout     (ram_dout),
      .samp         (samp),
      .samp_val     (samp_val),
      .busy         (busy),
      .led_o        (led)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (ram_rd_en) ram_dout <= mem[ram_addr];

   initial begin
      int tcnt;
      tcnt = 0;
      en   = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tick_on) begin
            en   = (tcnt == 0);
            tcnt = (tcnt + 1) % TP;
         end else begin
            en = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (en) last_tick = cyc;
      if (ram_rd_en) begin
         if (run == 0) start_q.push_back(cyc - last_tick);
         run++;
      end else if (run != 0) begin
         len_q.push_back(run);
         run = 0;
      end
      if (samp_val) begin
         samp_q.push_back(samp);
         lat_q.push_back(cyc - last_tick);
         scyc_q.push_back(cyc);
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: observed no finish, required finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 2*TP; i++) begin
         step_cyc(1);
         if (en) return;
      end
   endtask

   task automatic pulse_go();
      go = 1'b1;
      step_cyc(1);
      go = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      step_cyc(1);
      stop = 1'b0;
   endtask

   task automatic run_until(input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (samp_q.size() >= n) return;
         step_cyc(1);
      end
   endtask

   task automatic clear_q();
      samp_q.delete(); lat_q.delete(); scyc_q.delete(); start_q.delete(); len_q.delete();
   endtask

   function automatic logic [63:0] e4(input int a, input int b, input int c, input int d);
      return {16'(d*257), 16'(c*257), 16'(b*257), 16'(a*257)};
   endfunction

   function automatic logic [63:0] qs(input int i);
      return (i < samp_q.size()) ? samp_q[i] : 64'hx;
   endfunction

   function automatic logic [15:0] ch0(input int i);
      return (i < samp_q.size()) ? samp_q[i][15:0] : 16'hx;
   endfunction

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'((i % 256) * 257);
      rst = 1'b1; go = 1'b0; stop = 1'b0; tick_on = 1'b0;
      mode = 2'b00; nsamp = 11'd0; spd = 16'd0; phase = '0;
      step_cyc(3);
      chk("rst_samp", samp, 64'd0);
      chk("rst_samp_val", {63'd0, samp_val}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_rd_en", {63'd0, ram_rd_en}, 64'd0);
      chk("rst_addr", {54'd0, ram_addr}, 64'd0);
      chk("rst_led", {56'd0, led}, 64'd0);
      rst = 1'b0;
      tick_on = 1'b1;
      step_cyc(2*TP);

      // One-shot, nsamp=4, spd=2, phases 0/1/2/3
      mode = 2'b00; nsamp = 11'd4; spd = 16'd2; phase = {10'd3, 10'd2, 10'd1, 10'd0};
      clear_q();
      pulse_go();
      step_cyc(12*TP);
      chk("os_count", samp_q.size(), 4);
      chk("os_pub0", qs(0), e4(0, 1, 2, 3));
      chk("os_pub1", qs(1), e4(1, 2, 3, 0));
      chk("os_pub2", qs(2), e4(2, 3, 0, 1));
      chk("os_pub3", qs(3), e4(3, 0, 1, 2));
      for (int i = 0; i < 4; i++) begin
         chk("os_latency", (i < lat_q.size()) ? lat_q[i] : -1, 5);
         chk("os_rd_len", (i < len_q.size()) ? len_q[i] : -1, 4);
         chk("os_rd_start", (i < start_q.size()) ? start_q[i] : -1, 0);
      end
      for (int i = 0; i < 3; i++)
         chk("os_spacing", (i + 1 < scyc_q.size()) ? scyc_q[i+1] - scyc_q[i] : -1, 2*TP);
      chk("os_busy_end", {63'd0, busy}, 64'd0);
      chk("os_led", {56'd0, led}, 64'd3);
      chk("os_rd_idle", {63'd0, ram_rd_en}, 64'd0);

      // Continuous, nsamp=3, spd=1, then go+stop together on a tick
      mode = 2'b01; nsamp = 11'd3; spd = 16'd1; phase = '0;
      clear_q();
      pulse_go();
      step_cyc(7*TP);
      chk("cont_busy", {63'd0, busy}, 64'd1);
      chk("cont_s0", ch0(0), 16'd0);
      chk("cont_s1", ch0(1), 16'd257);
      chk("cont_s2", ch0(2), 16'd514);
      chk("cont_s3", ch0(3), 16'd0);
      chk("cont_s4", ch0(4), 16'd257);
      wait_tick();
      go = 1'b1; stop = 1'b1;
      #1;
      chk("stop_no_read", {63'd0, ram_rd_en}, 64'd0);
      step_cyc(1);
      go = 1'b0; stop = 1'b0;
      chk("stop_busy", {63'd0, busy}, 64'd0);
      clear_q();
      step_cyc(5*TP);
      chk("stop_no_strobe", samp_q.size(), 0);

      // Mode 10 with nsamp=4
`ifdef SAMP_GEN_MC_BOUNCE_EN
      bexp = '{0, 1, 2, 3, 2, 1, 0, 1};
`else
      bexp = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
      mode = 2'b10; nsamp = 11'd4; spd = 16'd1;
      clear_q();
      pulse_go();
      run_until(8, 12*TP);
      pulse_stop();
      step_cyc(3*TP);
      for (int i = 0; i < 8; i++) chk("bounce_seq", ch0(i), 16'(bexp[i]*257));
      chk("bounce_busy", {63'd0, busy}, 64'd0);

      mode = 2'b10; nsamp = 11'd1;
      clear_q();
      pulse_go();
      run_until(3, 6*TP);
      pulse_stop();
      step_cyc(3*TP);
      chk("bounce1_count", (samp_q.size() >= 3), 64'd1);
      for (int i = 0; i < 3; i++) chk("bounce1_seq", qs(i), e4(0, 0, 0, 0));

      // nsamp=0 go is dropped
      mode = 2'b00; nsamp = 11'd0; spd = 16'd1;
      clear_q();
      pulse_go();
      step_cyc(5*TP);
      chk("n0_count", samp_q.size(), 0);
      chk("n0_busy", {63'd0, busy}, 64'd0);

      // spd=0 behaves as spd=1
      mode = 2'b00; nsamp = 11'd2; spd = 16'd0; phase = '0;
      clear_q();
      pulse_go();
      step_cyc(6*TP);
      chk("spd0_count", samp_q.size(), 2);
      chk("spd0_spacing", (scyc_q.size() >= 2) ? scyc_q[1] - scyc_q[0] : -1, TP);
      chk("spd0_s1", ch0(1), 16'd257);

      // phase >= nsamp folds to 0
      mode = 2'b00; nsamp = 11'd3; spd = 16'd1; phase = {10'd2, 10'd5, 10'd3, 10'd0};
      clear_q();
      pulse_go();
      step_cyc(5*TP);
      chk("ph_count", samp_q.size(), 3);
      chk("ph_pub0", qs(0), e4(0, 0, 0, 2));
      chk("ph_pub1", qs(1), e4(1, 1, 1, 0));

      // One-shot restart with go during the final interval
      mode = 2'b00; nsamp = 11'd2; spd = 16'd2; phase = '0;
      clear_q();
      pulse_go();
      run_until(2, 4*TP);
      wait_tick();
      step_cyc(1);
      pulse_go();
      step_cyc(8*TP);
      chk("rs_count", samp_q.size(), 4);
      chk("rs_s2", ch0(2), 16'd0);
      chk("rs_s3", ch0(3), 16'd257);
      for (int i = 0; i < 3; i++)
         chk("rs_spacing", (i + 1 < scyc_q.size()) ? scyc_q[i+1] - scyc_q[i] : -1, 2*TP);
      chk("rs_busy", {63'd0, busy}, 64'd0);
      chk("rs_led", {56'd0, led}, 64'd1);

      // Reset at sequencer cycle 2
      mode = 2'b00; nsamp = 11'd4; spd = 16'd4; phase = {10'd3, 10'd2, 10'd1, 10'd0};
      clear_q();
      go = 1'b1;
      wait_tick();
      #1;
      chk("mr_rd0", {63'd0, ram_rd_en}, 64'd1);
      step_cyc(1);
      go = 1'b0;
      step_cyc(1);
      chk("mr_addr2", {54'd0, ram_addr}, 64'd2);
      rst = 1'b1;
      step_cyc(1);
      chk("mr_samp", samp, 64'd0);
      chk("mr_samp_val", {63'd0, samp_val}, 64'd0);
      chk("mr_busy", {63'd0, busy}, 64'd0);
      chk("mr_rd_en", {63'd0, ram_rd_en}, 64'd0);
      chk("mr_addr", {54'd0, ram_addr}, 64'd0);
      chk("mr_led", {56'd0, led}, 64'd0);
      rst = 1'b0;
      step_cyc(3*TP);
      chk("mr_no_strobe", samp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/samp_gen_mc.md
# samp_gen_mc

Multi-channel, multi-mode successor to the wave generator's sample generator. It steps a shared sample index at one step every `speed` decimated ticks. On each step it reads one sample per channel from a single-port sample RAM, each at its own phase offset, and publishes all channels together with one `samp_val` strobe. It sits between the command/register block (go, stop, mode, nsamp, speed, phase) and the sample RAM / DAC output path. Everything runs on `clk_tx`, gated by `en_clk_samp`.

## Interface
Parameters:
- `NSAMP_WID`, 10: address width; nsamp is coded naturally on `NSAMP_WID+1` bits.
- `NCHAN`, 4: number of output channels (1..16).
- `DATA_WID`, 16: sample width (≥ 8).

Ports:
- `clk_tx`, in, 1: the block's only clock.
- `rst_clk_tx`, in, 1: reset, synchronous to `clk_tx`, active-high.
- `en_clk_samp`, in, 1: one-cycle decimation tick. Period ≥ `NCHAN+2` clk_tx cycles.
- `go_clk_tx`, in, 1: start request, already synchronised, any width ≥ 1 cycle.
- `stop_clk_tx`, in, 1: stop request, already synchronised.
- `mode_clk_tx`, in, 2: 00 one-shot, 01 continuous, 10 bounce, 11 one-shot.
- `nsamp_clk_tx`, in, `NSAMP_WID+1`: number of samples per sweep.
- `spd_clk_tx`, in, 16: number of ticks per step.
- `phase_clk_tx`, in, `NCHAN*NSAMP_WID`: per-channel address offset; channel k occupies bits `[k*NSAMP_WID +: NSAMP_WID]`.
- `ram_addr`, out, `NSAMP_WID`: sample RAM address.
- `ram_rd_en`, out, 1: RAM read strobe. Data is on `ram_dout` on the following cycle.
- `ram_dout`, in, `DATA_WID`: RAM read data.
- `samp`, out, `NCHAN*DATA_WID`: published samples, channel k at `[k*DATA_WID +: DATA_WID]`.
- `samp_val`, out, 1: one-cycle strobe when `samp` updates.
- `busy`, out, 1: high while the run FSM is in RUN.
- `led_o`, out, 8: `samp[DATA_WID-1 -: 8]` of channel 0, registered.

## Operation
Request capture:
- A go or stop request sets a pending flag. The flag clears on the next `en_clk_samp` cycle, where the FSM consumes it.
- If a request and `en_clk_samp` coincide, the request is consumed directly.

Run FSM (IDLE/RUN), evaluated only on `en_clk_samp` cycles:
- IDLE → RUN on pending go, provided latched-to-be nsamp ≠ 0. If nsamp = 0, go is dropped and the FSM stays IDLE.
- On leaving IDLE, the FSM latches mode and nsamp, sets `samp_cnt`=0 and direction to up, and triggers a step immediately.
- Each step loads `speed_cnt` = max(spd,1) − 1. While `speed_cnt` ≠ 0 it decrements once per tick.
- When `speed_cnt` = 0 at a tick, a step event occurs: the index advances per the mode rules below, then the read sequence is launched.
- Pending stop at a tick: return to IDLE at that tick, with no further step and no read. Stop wins over a simultaneous go.

End-of-sweep rules, applied at `samp_cnt` = nsamp−1 (up direction):
- One-shot: if go is pending, restart at 0 and re-latch mode/nsamp. Otherwise go to IDLE. The last sample keeps its full speed interval before the FSM returns to IDLE.
- Continuous: wrap to 0 and re-latch mode/nsamp.
- Bounce: reverse direction; the sequence is 0,1,…,N−1,N−2,…,1,0,1,… with endpoints not repeated. nsamp=1 stays at index 0. Mode and nsamp are re-latched on return to index 0.

Read sequencer (starts on a step event; runs every clk_tx cycle):
- Cycle k = 0..NCHAN−1: `ram_rd_en`=1 and `ram_addr` = channel k address.
- Channel k address = (samp_cnt + phase_k) mod nsamp, computed on `NSAMP_WID+1` bits with one conditional subtract. A phase_k ≥ nsamp is treated as 0.
- Cycle k+1 captures `ram_dout` into staging register k.
- Cycle NCHAN+1 copies staging into `samp` for all channels at once and pulses `samp_val`. `led_o` updates on the following cycle.

## Timing
- Reset values: `samp`=0, `samp_val`=0, `busy`=0, `ram_rd_en`=0, `ram_addr`=0, `led_o`=0. Reset also clears FSM, pending flags, counters and sequencer. Reset mid-read aborts the read and no `samp_val` is produced.
- Latency from a step-event tick to `samp_val` is NCHAN+1 clk_tx cycles.
- `busy` rises the cycle after the go-consuming tick and falls the cycle after the final tick.
- A stop arriving mid-read lets the in-flight read sequence complete and publish.
- Between steps, `ram_addr` holds its last value and `ram_rd_en`=0.

## Configuration
- `SAMP_GEN_MC_BOUNCE_EN` defined: mode 10 is bounce as described above.
- `SAMP_GEN_MC_BOUNCE_EN` undefined: the direction logic is removed, and mode 10 behaves exactly as continuous (01).

## Test plan
- One-shot: NCHAN=4, nsamp=4, spd=2, phases 0/1/2/3, RAM[i]=i. Single go → 4 `samp_val` strobes 2 ticks apart. First publish is ch0..3 = 0,1,2,3; last is 3,0,1,2. `busy` then falls.
- Continuous with stop: nsamp=3, spd=1 → ch0 sequence 0,1,2,0,1,… Stop asserted in the same cycle as go at a later tick → IDLE at that tick, no further strobes.
- Bounce with macro defined: nsamp=4 → ch0 sequence 0,1,2,3,2,1,0,1. nsamp=1 → always 0. With the macro undefined, the same stimulus gives 0,1,2,3,0,1.
- Boundaries: nsamp=0 go → no strobe and `busy`=0. spd=0 behaves as spd=1. phase=nsamp behaves as phase 0. One-shot with go re-pulsed during the last interval → seamless restart at 0.
- Latency/reset: check `ram_rd_en` runs for exactly NCHAN cycles and `samp_val` arrives exactly NCHAN+1 cycles after the step tick. Assert reset at sequencer cycle 2 → all outputs 0 next cycle and no `samp_val`.
